// File: rtl/spu_issue_pkg.sv
// rtl/spu_issue_pkg.sv - shared types and opcode constants for the dual-pipe issue scheduler
package spu_issue_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SPLIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic {
        CLS_ODD  = 1'b0,
        CLS_EVEN = 1'b1
    } pipe_cls_t;

    localparam logic [0:10] NOP_EVEN = 11'b01000000001;
    localparam logic [0:10] NOP_ODD  = 11'b00000000001;
    localparam logic [0:10] STOP_OP  = 11'b00000000000;

    function automatic logic is_stop(input logic [0:31] ins);
        return ins[0:10] == STOP_OP;
    endfunction

endpackage

// File: rtl/issue_depchk.sv
// rtl/issue_depchk.sv - flags ins2 reading the register that ins1 writes
module issue_depchk (
    input  logic [0:6] rt_i,
    input  logic [0:6] ra_i,
    input  logic [0:6] rb_i,
    output logic       dep_o
);

    assign dep_o = (rt_i == ra_i) || (rt_i == rb_i);

endmodule

// File: rtl/issue_sched.sv
// rtl/issue_sched.sv - dual-issue scheduler routing an instruction pair onto even/odd pipes
// ISSUE_DEPCHK_EN enables the ins1->ins2 register dependency split.
module issue_sched
    import spu_issue_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        hazard_stall,
    input  logic [0:31] ins1,
    input  logic [0:31] ins2,
    input  logic        ins1_vld,
    input  logic        ins2_vld,
    input  logic        cls1,
    input  logic        cls2,
    input  logic [0:31] pc_in,
    output logic [0:31] even_ins,
    output logic [0:31] odd_ins,
    output logic [0:31] even_pc,
    output logic [0:31] odd_pc,
    output logic        even_vld,
    output logic        odd_vld,
    output logic        stall_fetch,
    output logic        halted
);

    localparam logic [0:31] NOP_EVEN_W = {NOP_EVEN, 21'b0};
    localparam logic [0:31] NOP_ODD_W  = {NOP_ODD, 21'b0};

    state_t      state_q, state_d;
    logic [0:31] lat_ins_q, lat_ins_d;
    logic [0:31] lat_pc_q, lat_pc_d;
    pipe_cls_t   lat_cls_q, lat_cls_d;

    logic [0:31] even_ins_q, even_ins_d, odd_ins_q, odd_ins_d;
    logic [0:31] even_pc_q, even_pc_d, odd_pc_q, odd_pc_d;
    logic        even_vld_q, even_vld_d, odd_vld_q, odd_vld_d;

    logic        dep;
    logic        pair_split;
    pipe_cls_t   c1, c2;
    logic [0:31] pc_plus4;

    // Up to two issue candidates per cycle, routed to pipes by their class
    logic        a_vld, b_vld;
    logic [0:31] a_ins, b_ins, a_pc, b_pc;
    pipe_cls_t   a_cls, b_cls;

`ifdef ISSUE_DEPCHK_EN
    issue_depchk u_depchk (
        .rt_i  (ins1[25:31]),
        .ra_i  (ins2[18:24]),
        .rb_i  (ins2[11:17]),
        .dep_o (dep)
    );
`else
    assign dep = 1'b0;
`endif

    assign c1         = pipe_cls_t'(cls1);
    assign c2         = pipe_cls_t'(cls2);
    assign pc_plus4   = pc_in + 32'd4;
    assign pair_split = ins1_vld && ins2_vld && ((c1 == c2) || dep);

    always_comb begin
        state_d     = state_q;
        lat_ins_d   = lat_ins_q;
        lat_pc_d    = lat_pc_q;
        lat_cls_d   = lat_cls_q;
        stall_fetch = 1'b0;
        a_vld       = 1'b0;
        a_ins       = ins1;
        a_pc        = pc_in;
        a_cls       = c1;
        b_vld       = 1'b0;
        b_ins       = ins2;
        b_pc        = pc_plus4;
        b_cls       = c2;
        even_ins_d  = NOP_EVEN_W;
        even_pc_d   = '0;
        even_vld_d  = 1'b0;
        odd_ins_d   = NOP_ODD_W;
        odd_pc_d    = '0;
        odd_vld_d   = 1'b0;

        case (state_q)
            HALT: stall_fetch = 1'b1;
            default: begin
                if (flush) begin
                    state_d   = RUN;
                    lat_ins_d = '0;
                    lat_pc_d  = '0;
                    lat_cls_d = CLS_ODD;
                end else if (hazard_stall) begin
                    stall_fetch = 1'b1;
                end else if (state_q == SPLIT) begin
                    a_vld   = 1'b1;
                    a_ins   = lat_ins_q;
                    a_pc    = lat_pc_q;
                    a_cls   = lat_cls_q;
                    state_d = RUN;
                end else if (pair_split) begin
                    a_vld       = 1'b1;
                    lat_ins_d   = ins2;
                    lat_pc_d    = pc_plus4;
                    lat_cls_d   = c2;
                    stall_fetch = 1'b1;
                    state_d     = SPLIT;
                end else begin
                    a_vld = ins1_vld;
                    b_vld = ins2_vld;
                end
            end
        endcase

        // Pair issue only happens when classes differ, so the two routes never collide
        if (a_vld) begin
            if (a_cls == CLS_EVEN) begin
                even_ins_d = a_ins;
                even_pc_d  = a_pc;
                even_vld_d = 1'b1;
            end else begin
                odd_ins_d = a_ins;
                odd_pc_d  = a_pc;
                odd_vld_d = 1'b1;
            end
        end
        if (b_vld) begin
            if (b_cls == CLS_EVEN) begin
                even_ins_d = b_ins;
                even_pc_d  = b_pc;
                even_vld_d = 1'b1;
            end else begin
                odd_ins_d = b_ins;
                odd_pc_d  = b_pc;
                odd_vld_d = 1'b1;
            end
        end

        if ((a_vld && is_stop(a_ins)) || (b_vld && is_stop(b_ins))) begin
            state_d   = HALT;
            lat_ins_d = '0;
            lat_pc_d  = '0;
            lat_cls_d = CLS_ODD;
        end

        if (reset) begin
            stall_fetch = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            lat_ins_q  <= '0;
            lat_pc_q   <= '0;
            lat_cls_q  <= CLS_ODD;
            even_ins_q <= NOP_EVEN_W;
            even_pc_q  <= '0;
            even_vld_q <= 1'b0;
            odd_ins_q  <= NOP_ODD_W;
            odd_pc_q   <= '0;
            odd_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_ins_q  <= lat_ins_d;
            lat_pc_q   <= lat_pc_d;
            lat_cls_q  <= lat_cls_d;
            even_ins_q <= even_ins_d;
            even_pc_q  <= even_pc_d;
            even_vld_q <= even_vld_d;
            odd_ins_q  <= odd_ins_d;
            odd_pc_q   <= odd_pc_d;
            odd_vld_q  <= odd_vld_d;
        end
    end

    assign even_ins = even_ins_q;
    assign even_pc  = even_pc_q;
    assign even_vld = even_vld_q;
    assign odd_ins  = odd_ins_q;
    assign odd_pc   = odd_pc_q;
    assign odd_vld  = odd_vld_q;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_issue_sched.sv
// tb/tb_issue_sched.sv - directed and randomized checks of issue_sched against a queue-based model
module tb_issue_sched;

`ifdef ISSUE_DEPCHK_EN
    localparam bit DEPCHK = 1'b1;
`else
    localparam bit DEPCHK = 1'b0;
`endif

    localparam logic [31:0] NOP_E = 32'h4020_0000;
    localparam logic [31:0] NOP_O = 32'h0020_0000;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        bit          even;
    } slot_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        hazard_stall = 1'b0;
    logic [31:0] ins1 = '0;
    logic [31:0] ins2 = '0;
    logic        ins1_vld = 1'b0;
    logic        ins2_vld = 1'b0;
    logic        cls1 = 1'b0;
    logic        cls2 = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] even_ins, odd_ins, even_pc, odd_pc;
    logic        even_vld, odd_vld, stall_fetch, halted;

    int n_cmp  = 0;
    int n_fail = 0;

    bit          m_halted = 1'b0;
    slot_t       m_pend[$];
    logic [31:0] exp_ev_ins, exp_od_ins, exp_ev_pc, exp_od_pc;
    logic        exp_ev_vld, exp_od_vld, exp_stall;

    issue_sched dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .ins1         (ins1),
        .ins2         (ins2),
        .ins1_vld     (ins1_vld),
        .ins2_vld     (ins2_vld),
        .cls1         (cls1),
        .cls2         (cls2),
        .pc_in        (pc_in),
        .even_ins     (even_ins),
        .odd_ins      (odd_ins),
        .even_pc      (even_pc),
        .odd_pc       (odd_pc),
        .even_vld     (even_vld),
        .odd_vld      (odd_vld),
        .stall_fetch  (stall_fetch),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input int unsigned op, input int unsigned rt,
                                       input int unsigned ra, input int unsigned rb);
        return 32'((op << 21) | ((rb & 32'h7f) << 14) | ((ra & 32'h7f) << 7) | (rt & 32'h7f));
    endfunction

    function automatic bit dep(input logic [31:0] a, input logic [31:0] b);
        int unsigned rt = a & 32'h7f;
        int unsigned ra = (b >> 7) & 32'h7f;
        int unsigned rb = (b >> 14) & 32'h7f;
        return DEPCHK && ((rt == ra) || (rt == rb));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        slot_t go[$];
        exp_ev_vld = 1'b0;
        exp_od_vld = 1'b0;
        exp_ev_ins = NOP_E;
        exp_od_ins = NOP_O;
        exp_ev_pc  = '0;
        exp_od_pc  = '0;
        exp_stall  = 1'b0;
        if (reset) begin
            m_halted = 1'b0;
            m_pend.delete();
        end else if (m_halted) begin
            exp_stall = 1'b1;
        end else if (flush) begin
            m_pend.delete();
        end else if (hazard_stall) begin
            exp_stall = 1'b1;
        end else begin
            if (m_pend.size() != 0) begin
                go.push_back(m_pend.pop_front());
            end else begin
                if (ins1_vld) go.push_back('{ins1, pc_in, cls1});
                if (ins2_vld) go.push_back('{ins2, pc_in + 32'd4, cls2});
                if (go.size() == 2 && (cls1 == cls2 || dep(ins1, ins2))) begin
                    m_pend.push_back(go.pop_back());
                    exp_stall = 1'b1;
                end
            end
            foreach (go[i]) begin
                if (go[i].even) begin
                    exp_ev_vld = 1'b1;
                    exp_ev_ins = go[i].ins;
                    exp_ev_pc  = go[i].pc;
                end else begin
                    exp_od_vld = 1'b1;
                    exp_od_ins = go[i].ins;
                    exp_od_pc  = go[i].pc;
                end
                if ((go[i].ins >> 21) == 0) m_halted = 1'b1;
            end
            if (m_halted) m_pend.delete();
        end
    endtask

    // Inputs are already driven; check the combinational stall, clock once, check the pipes
    task automatic step();
        #1;
        model_eval();
        check("stall_fetch", {31'b0, stall_fetch}, {31'b0, exp_stall});
        @(posedge clock);
        #1;
        check("even_vld", {31'b0, even_vld}, {31'b0, exp_ev_vld});
        check("odd_vld", {31'b0, odd_vld}, {31'b0, exp_od_vld});
        check("even_ins", even_ins, exp_ev_ins);
        check("odd_ins", odd_ins, exp_od_ins);
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        if (exp_ev_vld) check("even_pc", even_pc, exp_ev_pc);
        if (exp_od_vld) check("odd_pc", odd_pc, exp_od_pc);
    endtask

    task automatic idle_inputs();
        reset = 1'b0; flush = 1'b0; hazard_stall = 1'b0;
        ins1_vld = 1'b0; ins2_vld = 1'b0;
    endtask

    function automatic logic [31:0] rand_ins();
        int unsigned op = ($urandom_range(0, 39) == 0) ? 0 : $urandom_range(1, 2047);
        return 32'((op << 21) | ($urandom() & 32'h1f_ffff));
    endfunction

    initial begin
        int halt_cnt;
        // reset state
        reset = 1'b1;
        step();
        step();
        check("rst_even_ins", even_ins, NOP_E);
        check("rst_odd_ins", odd_ins, NOP_O);
        check("rst_even_pc", even_pc, 32'h0);
        check("rst_odd_pc", odd_pc, 32'h0);
        idle_inputs();

        // split pair to both pipes in one cycle
        ins1 = mk(12, 1, 9, 9); ins2 = mk(13, 4, 2, 3);
        ins1_vld = 1; ins2_vld = 1; cls1 = 1; cls2 = 0; pc_in = 32'h10;
        step();
        check("pair_even_pc", even_pc, 32'h10);
        check("pair_odd_pc", odd_pc, 32'h14);
        idle_inputs(); step();

        // same-class pair takes two cycles
        ins1 = mk(20, 1, 9, 9); ins2 = mk(21, 4, 2, 3);
        ins1_vld = 1; ins2_vld = 1; cls1 = 1; cls2 = 1; pc_in = 32'h20;
        #1 check("same_cls_stall", {31'b0, stall_fetch}, 32'h1);
        step();
        check("same_cls_pc1", even_pc, 32'h20);
        ins1 = mk(99, 0, 0, 0); cls1 = 0;
        step();
        check("same_cls_pc2", even_pc, 32'h24);
        idle_inputs(); step();

        // register dependency rt=5 -> ra=5
        ins1 = mk(30, 5, 1, 2); ins2 = mk(31, 6, 5, 7);
        ins1_vld = 1; ins2_vld = 1; cls1 = 1; cls2 = 0; pc_in = 32'h30;
        step();
        check("dep_odd_vld", {31'b0, odd_vld}, DEPCHK ? 32'h0 : 32'h1);
        idle_inputs(); step(); step();

        // stop freezes the block until reset
        ins1 = mk(0, 1, 2, 3); ins1_vld = 1; cls1 = 1; pc_in = 32'h50;
        step();
        check("stop_halted", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            ins1 = rand_ins(); ins2 = rand_ins();
            ins1_vld = 1'($urandom()); ins2_vld = 1'($urandom());
            flush = 1'($urandom()); hazard_stall = 1'($urandom());
            step();
            check("halt_stall", {31'b0, stall_fetch}, 32'h1);
        end
        idle_inputs(); reset = 1'b1;
        #1 check("rst_stall_low", {31'b0, stall_fetch}, 32'h0);
        step();
        check("rst_clears_halt", {31'b0, halted}, 32'h0);
        idle_inputs();

        // flush during SPLIT discards the latched ins2
        ins1 = mk(40, 1, 9, 9); ins2 = mk(41, 4, 2, 3);
        ins1_vld = 1; ins2_vld = 1; cls1 = 0; cls2 = 0; pc_in = 32'h60;
        step();
        idle_inputs(); flush = 1'b1;
        step();
        check("flush_odd_vld", {31'b0, odd_vld}, 32'h0);
        idle_inputs(); step();
        check("flush_no_ins2", {31'b0, odd_vld}, 32'h0);

        // odd branch target: only ins2 valid
        ins2 = mk(50, 1, 2, 3); ins2_vld = 1; cls2 = 0; pc_in = 32'h40;
        step();
        check("odd_tgt_pc", odd_pc, 32'h44);
        check("odd_tgt_even_vld", {31'b0, even_vld}, 32'h0);
        idle_inputs();

        // randomized traffic
        halt_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = (halt_cnt > 4) || ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 11) == 0);
            hazard_stall = ($urandom_range(0, 7) == 0);
            ins1 = rand_ins(); ins2 = rand_ins();
            if ($urandom_range(0, 2) == 0) ins2 = mk(32'(ins2 >> 21), 3, 32'(ins1 & 32'h7f), 9);
            if ($urandom_range(0, 3) == 0) ins2 = mk(32'(ins2 >> 21), 3, 8, 32'(ins1 & 32'h7f));
            ins1_vld = ($urandom_range(0, 4) != 0);
            ins2_vld = ($urandom_range(0, 4) != 0);
            cls1 = 1'($urandom()); cls2 = 1'($urandom());
            pc_in = $urandom() & 32'hffff_fff8;
            step();
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
